// File: rtl/execute_if.sv
// Bundle of signals between the ID/EX register, the EX stage and the memory
// stage. The EX stage sits on the slave side. The master side is whatever
// drives the ID/EX values and observes the EX/MEM outputs.
interface execute_if #(
    parameter int WIDTH = 16,
    parameter int RW    = 3
);
    logic             stall;
    logic             flush;
    logic [WIDTH-1:0] Rd1_IDEX;
    logic [WIDTH-1:0] Rd2_IDEX;
    logic [WIDTH-1:0] Imm_IDEX;
    logic [WIDTH-1:0] PCInc_IDEX;
    logic [RW-1:0]    Rs_IDEX;
    logic [RW-1:0]    Rt_IDEX;
    logic [3:0]       ALUOp_IDEX;
    logic             ALUSrc_IDEX;
    logic [2:0]       BrType_IDEX;
    logic             MemWrite_IDEX;
    logic             MemRead_IDEX;
    logic             MemtoReg_IDEX;
    logic             RegWrite_IDEX;
    logic             Dump_IDEX;
    logic             halt_IDEX;
    logic [RW-1:0]    WrR_IDEX;
    logic             RegWrite_MEMWB;
    logic [RW-1:0]    WrR_MEMWB;
    logic [WIDTH-1:0] WrD_MEMWB;

    logic             takeBranch;
    logic [WIDTH-1:0] brTarget;
    logic [WIDTH-1:0] ALUO_EXMEM;
    logic [WIDTH-1:0] Rd2_EXMEM;
    logic [RW-1:0]    WrR_EXMEM;
    logic             takeBranch_EXMEM;
    logic             MemWrite_EXMEM;
    logic             MemRead_EXMEM;
    logic             MemtoReg_EXMEM;
    logic             RegWrite_EXMEM;
    logic             Dump_EXMEM;
    logic             halt_EXMEM;

    modport slave (
        input  stall, flush, Rd1_IDEX, Rd2_IDEX, Imm_IDEX, PCInc_IDEX,
               Rs_IDEX, Rt_IDEX, ALUOp_IDEX, ALUSrc_IDEX, BrType_IDEX,
               MemWrite_IDEX, MemRead_IDEX, MemtoReg_IDEX, RegWrite_IDEX,
               Dump_IDEX, halt_IDEX, WrR_IDEX,
               RegWrite_MEMWB, WrR_MEMWB, WrD_MEMWB,
        output takeBranch, brTarget, ALUO_EXMEM, Rd2_EXMEM, WrR_EXMEM,
               takeBranch_EXMEM, MemWrite_EXMEM, MemRead_EXMEM,
               MemtoReg_EXMEM, RegWrite_EXMEM, Dump_EXMEM, halt_EXMEM
    );

    modport master (
        output stall, flush, Rd1_IDEX, Rd2_IDEX, Imm_IDEX, PCInc_IDEX,
               Rs_IDEX, Rt_IDEX, ALUOp_IDEX, ALUSrc_IDEX, BrType_IDEX,
               MemWrite_IDEX, MemRead_IDEX, MemtoReg_IDEX, RegWrite_IDEX,
               Dump_IDEX, halt_IDEX, WrR_IDEX,
               RegWrite_MEMWB, WrR_MEMWB, WrD_MEMWB,
        input  takeBranch, brTarget, ALUO_EXMEM, Rd2_EXMEM, WrR_EXMEM,
               takeBranch_EXMEM, MemWrite_EXMEM, MemRead_EXMEM,
               MemtoReg_EXMEM, RegWrite_EXMEM, Dump_EXMEM, halt_EXMEM
    );
endinterface

// File: rtl/execute.sv
// EX stage of the 5-stage pipeline. It forwards operands from EX/MEM and
// MEM/WB, runs the 16-bit ALU, resolves branches and jumps back to fetch,
// and owns the EX/MEM pipeline register that feeds the memory stage.
module execute #(
    parameter int WIDTH = 16,
    parameter int RW    = 3
) (
    input logic       clk,
    input logic       rst,
    execute_if.slave  ex
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_XOR    = 4'h2;
    localparam logic [3:0] OP_ANDN   = 4'h3;
    localparam logic [3:0] OP_ROL    = 4'h4;
    localparam logic [3:0] OP_SLL    = 4'h5;
    localparam logic [3:0] OP_ROR    = 4'h6;
    localparam logic [3:0] OP_SRL    = 4'h7;
    localparam logic [3:0] OP_SEQ    = 4'h8;
    localparam logic [3:0] OP_SLT    = 4'h9;
    localparam logic [3:0] OP_SLE    = 4'hA;
    localparam logic [3:0] OP_SCO    = 4'hB;
    localparam logic [3:0] OP_BTR    = 4'hC;
    localparam logic [3:0] OP_PASSB  = 4'hD;
    localparam logic [3:0] OP_PCLINK = 4'hE;

    localparam logic [2:0] BR_BEQZ = 3'd1;
    localparam logic [2:0] BR_BNEZ = 3'd2;
    localparam logic [2:0] BR_BLTZ = 3'd3;
    localparam logic [2:0] BR_BGEZ = 3'd4;
    localparam logic [2:0] BR_J    = 3'd5;
    localparam logic [2:0] BR_JR   = 3'd6;

    // EX/MEM pipeline register state and its next-state values
    logic [WIDTH-1:0] aluo_q,     aluo_d;
    logic [WIDTH-1:0] rd2_q,      rd2_d;
    logic [RW-1:0]    wrR_q,      wrR_d;
    logic             takeBr_q,   takeBr_d;
    logic             memWrite_q, memWrite_d;
    logic             memRead_q,  memRead_d;
    logic             memtoReg_q, memtoReg_d;
    logic             regWrite_q, regWrite_d;
    logic             dump_q,     dump_d;
    logic             halt_q,     halt_d;

    logic [WIDTH-1:0] fwdA;
    logic [WIDTH-1:0] fwdB;
    logic [WIDTH-1:0] opB;
    logic [WIDTH-1:0] aluResult;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] reversed;
    logic [SHW-1:0]   shAmt;
    logic [SHW:0]     shBack;
    logic             brCond;
    logic             takeBranch;
    logic [WIDTH-1:0] brTarget;

    // Operand forwarding: a non-load result in EX/MEM beats the value being
    // written back, which beats the stale register-file read.
    always_comb begin
        fwdA = ex.Rd1_IDEX;
        fwdB = ex.Rd2_IDEX;
        if (regWrite_q && !memtoReg_q && (wrR_q == ex.Rs_IDEX)) begin
            fwdA = aluo_q;
        end else if (ex.RegWrite_MEMWB && (ex.WrR_MEMWB == ex.Rs_IDEX)) begin
            fwdA = ex.WrD_MEMWB;
        end
        if (regWrite_q && !memtoReg_q && (wrR_q == ex.Rt_IDEX)) begin
            fwdB = aluo_q;
        end else if (ex.RegWrite_MEMWB && (ex.WrR_MEMWB == ex.Rt_IDEX)) begin
            fwdB = ex.WrD_MEMWB;
        end
        opB = ex.ALUSrc_IDEX ? ex.Imm_IDEX : fwdB;
    end

    // ALU: arithmetic wraps, shifts and rotates use the low bits of B
    always_comb begin
        aluResult = '0;
        shAmt     = opB[SHW-1:0];
        shBack    = (SHW+1)'(WIDTH) - {1'b0, shAmt};
        sum       = {1'b0, fwdA} + {1'b0, opB};
        reversed  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            reversed[i] = fwdA[WIDTH-1-i];
        end
        case (ex.ALUOp_IDEX)
            OP_ADD:    aluResult = sum[WIDTH-1:0];
            OP_SUB:    aluResult = opB - fwdA;
            OP_XOR:    aluResult = fwdA ^ opB;
            OP_ANDN:   aluResult = fwdA & ~opB;
            OP_ROL:    aluResult = (fwdA << shAmt) | (fwdA >> shBack);
            OP_SLL:    aluResult = fwdA << shAmt;
            OP_ROR:    aluResult = (fwdA >> shAmt) | (fwdA << shBack);
            OP_SRL:    aluResult = fwdA >> shAmt;
            OP_SEQ:    aluResult = {{(WIDTH-1){1'b0}}, fwdA == opB};
            OP_SLT:    aluResult = {{(WIDTH-1){1'b0}}, $signed(fwdA) < $signed(opB)};
            OP_SLE:    aluResult = {{(WIDTH-1){1'b0}}, $signed(fwdA) <= $signed(opB)};
            OP_SCO:    aluResult = {{(WIDTH-1){1'b0}}, sum[WIDTH]};
            OP_BTR:    aluResult = reversed;
            OP_PASSB:  aluResult = opB;
            OP_PCLINK: aluResult = ex.PCInc_IDEX;
            default:   aluResult = '0;
        endcase
    end

    // Branch resolution: condition on forwarded A, redirect suppressed while
    // the pipe is stalled or this slot is being flushed
    always_comb begin
        brCond   = 1'b0;
        brTarget = ex.PCInc_IDEX + ex.Imm_IDEX;
        case (ex.BrType_IDEX)
            BR_BEQZ: brCond = (fwdA == '0);
            BR_BNEZ: brCond = (fwdA != '0);
            BR_BLTZ: brCond = fwdA[WIDTH-1];
            BR_BGEZ: brCond = !fwdA[WIDTH-1];
            BR_J:    brCond = 1'b1;
            BR_JR: begin
                brCond   = 1'b1;
                brTarget = fwdA + ex.Imm_IDEX;
            end
            default: brCond = 1'b0;
        endcase
        takeBranch = brCond && !ex.stall && !ex.flush;
    end

    // EX/MEM next state: stall holds everything, flush zeroes the control
    // bits and lets data through as don't-care, otherwise load the new result
    always_comb begin
        aluo_d     = aluo_q;
        rd2_d      = rd2_q;
        wrR_d      = wrR_q;
        takeBr_d   = takeBr_q;
        memWrite_d = memWrite_q;
        memRead_d  = memRead_q;
        memtoReg_d = memtoReg_q;
        regWrite_d = regWrite_q;
        dump_d     = dump_q;
        halt_d     = halt_q;
        if (!ex.stall) begin
            aluo_d = aluResult;
            rd2_d  = fwdB;
            wrR_d  = ex.WrR_IDEX;
            if (ex.flush) begin
                takeBr_d   = 1'b0;
                memWrite_d = 1'b0;
                memRead_d  = 1'b0;
                memtoReg_d = 1'b0;
                regWrite_d = 1'b0;
                dump_d     = 1'b0;
                halt_d     = 1'b0;
            end else begin
                takeBr_d   = takeBranch;
                memWrite_d = ex.MemWrite_IDEX;
                memRead_d  = ex.MemRead_IDEX;
                memtoReg_d = ex.MemtoReg_IDEX;
                regWrite_d = ex.RegWrite_IDEX;
                dump_d     = ex.Dump_IDEX;
                halt_d     = ex.halt_IDEX;
            end
        end
    end

    // EX/MEM register; reset presents a NOP bubble to the memory stage
    always_ff @(posedge clk) begin
        if (rst) begin
            aluo_q     <= '0;
            rd2_q      <= '0;
            wrR_q      <= '0;
            takeBr_q   <= 1'b0;
            memWrite_q <= 1'b0;
            memRead_q  <= 1'b0;
            memtoReg_q <= 1'b0;
            regWrite_q <= 1'b0;
            dump_q     <= 1'b0;
            halt_q     <= 1'b0;
        end else begin
            aluo_q     <= aluo_d;
            rd2_q      <= rd2_d;
            wrR_q      <= wrR_d;
            takeBr_q   <= takeBr_d;
            memWrite_q <= memWrite_d;
            memRead_q  <= memRead_d;
            memtoReg_q <= memtoReg_d;
            regWrite_q <= regWrite_d;
            dump_q     <= dump_d;
            halt_q     <= halt_d;
        end
    end

    assign ex.takeBranch       = takeBranch;
    assign ex.brTarget         = brTarget;
    assign ex.ALUO_EXMEM       = aluo_q;
    assign ex.Rd2_EXMEM        = rd2_q;
    assign ex.WrR_EXMEM        = wrR_q;
    assign ex.takeBranch_EXMEM = takeBr_q;
    assign ex.MemWrite_EXMEM   = memWrite_q;
    assign ex.MemRead_EXMEM    = memRead_q;
    assign ex.MemtoReg_EXMEM   = memtoReg_q;
    assign ex.RegWrite_EXMEM   = regWrite_q;
    assign ex.Dump_EXMEM       = dump_q;
    assign ex.halt_EXMEM       = halt_q;
endmodule

// File: tb/tb_execute.sv
// Bench for the EX stage: directed scenarios followed by random instruction
// streams, all compared against a behavioural model of the EX/MEM register.
module tb_execute;
    logic clk = 1'b0;
    logic rst;

    execute_if bus ();

    execute dut (
        .clk (clk),
        .rst (rst),
        .ex  (bus)
    );

    // Free-running clock
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] mAluo = '0;
    logic [15:0] mRd2  = '0;
    logic [2:0]  mWrR  = '0;
    logic        mTb = 1'b0, mMw = 1'b0, mMr = 1'b0, mM2r = 1'b0;
    logic        mRw = 1'b0, mDump = 1'b0, mHalt = 1'b0;
    logic        mDataValid = 1'b0;

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int toSigned(input logic [15:0] v);
        return v[15] ? int'(v) - 65536 : int'(v);
    endfunction

    function automatic logic [15:0] refAlu(input logic [3:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic [15:0] pc);
        int          s;
        int          ua;
        int          ub;
        logic [15:0] r;
        s  = int'(b[3:0]);
        ua = int'(a);
        ub = int'(b);
        r  = a;
        case (op)
            4'h0: return 16'(ua + ub);
            4'h1: return 16'(ub - ua);
            4'h2: return a ^ b;
            4'h3: return a & ~b;
            4'h4: begin
                for (int i = 0; i < s; i++) r = {r[14:0], r[15]};
                return r;
            end
            4'h5: return 16'(ua * (1 << s));
            4'h6: begin
                for (int i = 0; i < s; i++) r = {r[0], r[15:1]};
                return r;
            end
            4'h7: return 16'(ua / (1 << s));
            4'h8: return (a == b) ? 16'd1 : 16'd0;
            4'h9: return (toSigned(a) < toSigned(b)) ? 16'd1 : 16'd0;
            4'hA: return (toSigned(a) <= toSigned(b)) ? 16'd1 : 16'd0;
            4'hB: return (ua + ub > 65535) ? 16'd1 : 16'd0;
            4'hC: begin
                for (int i = 0; i < 16; i++) r[i] = a[15-i];
                return r;
            end
            4'hD: return b;
            4'hE: return pc;
            default: return 16'd0;
        endcase
    endfunction

    task automatic setNop();
        bus.stall          = 1'b0;
        bus.flush          = 1'b0;
        bus.Rd1_IDEX       = '0;
        bus.Rd2_IDEX       = '0;
        bus.Imm_IDEX       = '0;
        bus.PCInc_IDEX     = '0;
        bus.Rs_IDEX        = '0;
        bus.Rt_IDEX        = '0;
        bus.ALUOp_IDEX     = '0;
        bus.ALUSrc_IDEX    = 1'b0;
        bus.BrType_IDEX    = '0;
        bus.MemWrite_IDEX  = 1'b0;
        bus.MemRead_IDEX   = 1'b0;
        bus.MemtoReg_IDEX  = 1'b0;
        bus.RegWrite_IDEX  = 1'b0;
        bus.Dump_IDEX      = 1'b0;
        bus.halt_IDEX      = 1'b0;
        bus.WrR_IDEX       = '0;
        bus.RegWrite_MEMWB = 1'b0;
        bus.WrR_MEMWB      = '0;
        bus.WrD_MEMWB      = '0;
    endtask

    // One instruction slot: check the branch redirect against the model,
    // clock the edge, advance the model and check the EX/MEM register.
    task automatic applyStimulus(input string tag);
        logic [15:0] fa, fb, opb, res, tgt;
        logic        cond, expTake;
        #1;
        fa = bus.Rd1_IDEX;
        if (mRw && !mM2r && mWrR == bus.Rs_IDEX) fa = mAluo;
        else if (bus.RegWrite_MEMWB && bus.WrR_MEMWB == bus.Rs_IDEX) fa = bus.WrD_MEMWB;
        fb = bus.Rd2_IDEX;
        if (mRw && !mM2r && mWrR == bus.Rt_IDEX) fb = mAluo;
        else if (bus.RegWrite_MEMWB && bus.WrR_MEMWB == bus.Rt_IDEX) fb = bus.WrD_MEMWB;
        opb = bus.ALUSrc_IDEX ? bus.Imm_IDEX : fb;
        res = refAlu(bus.ALUOp_IDEX, fa, opb, bus.PCInc_IDEX);
        case (bus.BrType_IDEX)
            3'd1:    cond = (fa == 16'd0);
            3'd2:    cond = (fa != 16'd0);
            3'd3:    cond = (toSigned(fa) < 0);
            3'd4:    cond = (toSigned(fa) >= 0);
            3'd5:    cond = 1'b1;
            3'd6:    cond = 1'b1;
            default: cond = 1'b0;
        endcase
        tgt = (bus.BrType_IDEX == 3'd6) ? 16'(int'(fa) + int'(bus.Imm_IDEX))
                                        : 16'(int'(bus.PCInc_IDEX) + int'(bus.Imm_IDEX));
        expTake = cond && !bus.stall && !bus.flush;
        checkOutput({tag, ":takeBranch"}, 16'(bus.takeBranch), 16'(expTake));
        if (expTake) checkOutput({tag, ":brTarget"}, bus.brTarget, tgt);
        @(posedge clk);
        if (rst) begin
            {mAluo, mRd2, mWrR} = '0;
            {mTb, mMw, mMr, mM2r, mRw, mDump, mHalt} = '0;
            mDataValid = 1'b1;
        end else if (bus.stall) begin
            mDataValid = mDataValid;
        end else if (bus.flush) begin
            {mTb, mMw, mMr, mM2r, mRw, mDump, mHalt} = '0;
            mDataValid = 1'b0;
        end else begin
            mAluo = res;
            mRd2  = fb;
            mWrR  = bus.WrR_IDEX;
            mTb   = expTake;
            mMw   = bus.MemWrite_IDEX;
            mMr   = bus.MemRead_IDEX;
            mM2r  = bus.MemtoReg_IDEX;
            mRw   = bus.RegWrite_IDEX;
            mDump = bus.Dump_IDEX;
            mHalt = bus.halt_IDEX;
            mDataValid = 1'b1;
        end
        #1;
        checkOutput({tag, ":ctrl"},
                    16'({bus.takeBranch_EXMEM, bus.MemWrite_EXMEM, bus.MemRead_EXMEM,
                         bus.MemtoReg_EXMEM, bus.RegWrite_EXMEM, bus.Dump_EXMEM, bus.halt_EXMEM}),
                    16'({mTb, mMw, mMr, mM2r, mRw, mDump, mHalt}));
        if (mDataValid) begin
            checkOutput({tag, ":ALUO"}, bus.ALUO_EXMEM, mAluo);
            checkOutput({tag, ":Rd2"},  bus.Rd2_EXMEM,  mRd2);
            checkOutput({tag, ":WrR"},  16'(bus.WrR_EXMEM), 16'(mWrR));
        end
    endtask

    // Directed scenarios, then a random instruction stream
    initial begin
        rst = 1'b1;
        setNop();
        applyStimulus("rst0");
        applyStimulus("rst1");
        checkOutput("rst_aluo", bus.ALUO_EXMEM, 16'h0000);
        checkOutput("rst_regwrite", 16'(bus.RegWrite_EXMEM), 16'h0000);

        rst = 1'b0;
        applyStimulus("nop");
        checkOutput("nop_memwrite", 16'(bus.MemWrite_EXMEM), 16'h0000);

        bus.ALUOp_IDEX = 4'h0; bus.Rd1_IDEX = 16'h7FFF; bus.Rd2_IDEX = 16'h0001;
        bus.Rs_IDEX = 3'd1; bus.Rt_IDEX = 3'd2;
        applyStimulus("add_ovf");
        checkOutput("add_ovf_val", bus.ALUO_EXMEM, 16'h8000);

        bus.ALUOp_IDEX = 4'hB; bus.Rd1_IDEX = 16'hFFFF; bus.Rd2_IDEX = 16'h0001;
        applyStimulus("sco");
        checkOutput("sco_val", bus.ALUO_EXMEM, 16'h0001);

        bus.ALUOp_IDEX = 4'h4; bus.Rd1_IDEX = 16'h8001; bus.Rd2_IDEX = 16'h0004;
        applyStimulus("rol");
        checkOutput("rol_val", bus.ALUO_EXMEM, 16'h0018);

        setNop();
        bus.ALUOp_IDEX = 4'hD; bus.ALUSrc_IDEX = 1'b1; bus.Imm_IDEX = 16'h0005;
        bus.RegWrite_IDEX = 1'b1; bus.WrR_IDEX = 3'd3;
        applyStimulus("lbi_r3");
        setNop();
        bus.ALUOp_IDEX = 4'h0; bus.Rs_IDEX = 3'd3; bus.Rd1_IDEX = 16'h0000;
        bus.ALUSrc_IDEX = 1'b1; bus.Imm_IDEX = 16'h0002;
        applyStimulus("fwd_exmem");
        checkOutput("fwd_exmem_val", bus.ALUO_EXMEM, 16'h0007);
        bus.Rs_IDEX = 3'd4; bus.Imm_IDEX = 16'h0001;
        bus.RegWrite_MEMWB = 1'b1; bus.WrR_MEMWB = 3'd4; bus.WrD_MEMWB = 16'h0100;
        applyStimulus("fwd_memwb");
        checkOutput("fwd_memwb_val", bus.ALUO_EXMEM, 16'h0101);

        setNop();
        bus.BrType_IDEX = 3'd1; bus.Rs_IDEX = 3'd5; bus.Rd1_IDEX = 16'h0000;
        bus.PCInc_IDEX = 16'h0010; bus.Imm_IDEX = 16'hFFF8;
        #1;
        checkOutput("beqz_take", 16'(bus.takeBranch), 16'h0001);
        checkOutput("beqz_target", bus.brTarget, 16'h0008);
        applyStimulus("beqz");
        checkOutput("beqz_exmem", 16'(bus.takeBranch_EXMEM), 16'h0001);
        bus.Rd1_IDEX = 16'h0001;
        #1;
        checkOutput("beqz_nottaken", 16'(bus.takeBranch), 16'h0000);
        applyStimulus("beqz_nt");

        setNop();
        bus.ALUOp_IDEX = 4'h0; bus.Rd1_IDEX = 16'h0020; bus.ALUSrc_IDEX = 1'b1;
        bus.Imm_IDEX = 16'h0004; bus.Rd2_IDEX = 16'hBEEF; bus.Rs_IDEX = 3'd1;
        bus.Rt_IDEX = 3'd2; bus.MemWrite_IDEX = 1'b1;
        applyStimulus("store");
        setNop();
        bus.stall = 1'b1; bus.BrType_IDEX = 3'd2; bus.Rs_IDEX = 3'd6;
        bus.Rd1_IDEX = 16'h0001; bus.PCInc_IDEX = 16'h0040; bus.Imm_IDEX = 16'h0010;
        bus.RegWrite_IDEX = 1'b1;
        #1;
        checkOutput("stall_bnez_blocked", 16'(bus.takeBranch), 16'h0000);
        for (int i = 0; i < 3; i++) begin
            applyStimulus("stall");
            checkOutput("stall_memwrite", 16'(bus.MemWrite_EXMEM), 16'h0001);
            checkOutput("stall_aluo", bus.ALUO_EXMEM, 16'h0024);
            checkOutput("stall_rd2", bus.Rd2_EXMEM, 16'hBEEF);
        end
        bus.stall = 1'b0;
        #1;
        checkOutput("unstall_bnez", 16'(bus.takeBranch), 16'h0001);
        applyStimulus("bnez");

        setNop();
        bus.flush = 1'b1; bus.RegWrite_IDEX = 1'b1; bus.MemWrite_IDEX = 1'b1;
        bus.halt_IDEX = 1'b1; bus.BrType_IDEX = 3'd5;
        applyStimulus("flush");
        checkOutput("flush_regwrite", 16'(bus.RegWrite_EXMEM), 16'h0000);
        checkOutput("flush_memwrite", 16'(bus.MemWrite_EXMEM), 16'h0000);

        setNop();
        bus.ALUOp_IDEX = 4'hD; bus.ALUSrc_IDEX = 1'b1; bus.Imm_IDEX = 16'h0055;
        bus.RegWrite_IDEX = 1'b1; bus.WrR_IDEX = 3'd2;
        applyStimulus("preload");
        setNop();
        bus.stall = 1'b1; bus.flush = 1'b1; bus.Imm_IDEX = 16'h1234;
        bus.ALUSrc_IDEX = 1'b1; bus.ALUOp_IDEX = 4'hD;
        applyStimulus("stallflush");
        checkOutput("stallflush_regwrite", 16'(bus.RegWrite_EXMEM), 16'h0001);
        checkOutput("stallflush_aluo", bus.ALUO_EXMEM, 16'h0055);

        for (int n = 0; n < 400; n++) begin
            rst                = ($urandom_range(0, 49) == 0);
            bus.stall          = ($urandom_range(0, 7) == 0);
            bus.flush          = ($urandom_range(0, 7) == 0);
            bus.Rd1_IDEX       = 16'($urandom);
            bus.Rd2_IDEX       = 16'($urandom);
            bus.Imm_IDEX       = 16'($urandom);
            bus.PCInc_IDEX     = 16'($urandom);
            bus.Rs_IDEX        = 3'($urandom_range(0, 3));
            bus.Rt_IDEX        = 3'($urandom_range(0, 3));
            bus.ALUOp_IDEX     = 4'($urandom);
            bus.ALUSrc_IDEX    = 1'($urandom);
            bus.BrType_IDEX    = 3'($urandom);
            bus.MemWrite_IDEX  = 1'($urandom);
            bus.MemRead_IDEX   = 1'($urandom);
            bus.MemtoReg_IDEX  = 1'($urandom);
            bus.RegWrite_IDEX  = 1'($urandom);
            bus.Dump_IDEX      = 1'($urandom);
            bus.halt_IDEX      = ($urandom_range(0, 9) == 0);
            bus.WrR_IDEX       = 3'($urandom_range(0, 3));
            bus.RegWrite_MEMWB = 1'($urandom);
            bus.WrR_MEMWB      = 3'($urandom_range(0, 3));
            bus.WrD_MEMWB      = 16'($urandom);
            applyStimulus("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
